// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory controller: size codes,
// controller states and the byte-lane mask helper.
package dmem_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Half selects its lane pair from off[1] only, so addr[0] never shifts it.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: merges store data into an old word under
// a lane mask, and extracts/extends a sized little-endian load from a word.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [WORD_W-1:0] i_old_word,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [3:0]        i_mask,
   input  logic [1:0]        i_size,
   input  logic [WORD_W-1:0] i_rword,
   input  logic [1:0]        i_offset,
   input  logic              i_unsigned,
   output logic [WORD_W-1:0] o_new_word,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] w_wdata_rep;
   logic [7:0]        w_rbyte;
   logic [15:0]       w_rhalf;

   // Replicating right-aligned store data puts it in every lane it could target.
   always_comb begin
      w_wdata_rep = i_wdata;
      case (i_size)
         SZ_BYTE: w_wdata_rep = {4{i_wdata[7:0]}};
         SZ_HALF: w_wdata_rep = {2{i_wdata[15:0]}};
         default: w_wdata_rep = i_wdata;
      endcase
      o_new_word = i_old_word;
      for (int b = 0; b < 4; b++) begin
         if (i_mask[b]) o_new_word[8*b +: 8] = w_wdata_rep[8*b +: 8];
      end
   end

   always_comb begin
      w_rbyte = i_rword[{i_offset, 3'b000} +: 8];
      w_rhalf = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
      o_rdata = '0;
      case (i_size)
         SZ_BYTE: o_rdata = {{24{~i_unsigned & w_rbyte[7]}}, w_rbyte};
         SZ_HALF: o_rdata = {{16{~i_unsigned & w_rhalf[15]}}, w_rhalf};
         SZ_WORD: o_rdata = i_rword;
         default: o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Data memory controller with valid/ready requests, sized loads/stores and
// WAIT_CYCLES stall states. Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses.
module dmem_banked_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 8192,
   parameter int ADDR_W      = 32,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e            r_state;
   state_e            w_next_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic              r_unsigned;
   logic [1:0]        r_size;
   logic [1:0]        r_off;
   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] r_wdata;
   logic [WORD_W-1:0] r_rdata;
   logic              r_err;
   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

   logic              w_accept;
   logic              w_commit;
   logic              w_err;
   logic [3:0]        w_mask;
   logic [WORD_W-1:0] w_old_word;
   logic [WORD_W-1:0] w_new_word;
   logic [WORD_W-1:0] w_load_data;
   logic              w_unused_addr;

   // Upper address bits alias by design; fold them away explicitly.
   assign w_unused_addr = ^req_addr;

   assign w_accept   = (r_state == ST_IDLE) && req_valid;
   assign w_commit   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
   assign w_mask     = lane_mask(r_size, r_off);
   assign w_old_word = r_mem[r_idx];

`ifdef DMEM_ALIGN_CHECK_EN
   logic w_misalign;
   assign w_misalign = ((r_size == SZ_HALF) && r_off[0]) ||
                       ((r_size == SZ_WORD) && (r_off != 2'b00));
   assign w_err      = (r_size == SZ_RSVD) || w_misalign;
`else
   assign w_err      = (r_size == SZ_RSVD);
`endif

   dmem_lane_align u_lane_align (
      .i_old_word (w_old_word),
      .i_wdata    (r_wdata),
      .i_mask     (w_mask),
      .i_size     (r_size),
      .i_rword    (w_old_word),
      .i_offset   (r_off),
      .i_unsigned (r_unsigned),
      .o_new_word (w_new_word),
      .o_rdata    (w_load_data)
   );

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (req_valid) w_next_state = ST_BUSY;
         ST_BUSY: if (r_cnt == 4'd0) w_next_state = ST_RESP;
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_cnt <= 4'(WAIT_CYCLES);
         end else if (r_state == ST_BUSY && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_commit) begin
            r_rdata <= (r_write || w_err) ? '0 : w_load_data;
            r_err   <= w_err;
         end
      end
   end

   // Request fields are data only; they are qualified by the state register.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_write    <= req_write;
         r_unsigned <= req_unsigned;
         r_size     <= req_size;
         r_off      <= req_addr[1:0];
         r_idx      <= req_addr[2 +: IDX_W];
         r_wdata    <= req_wdata;
      end
   end

   // An asynchronous reset forces IDLE, so a pending store can never commit.
   always_ff @(posedge clock) begin
      if (w_commit && r_write && !w_err) begin
         r_mem[r_idx] <= w_new_word;
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Directed self-checking bench: three controller instances (WAIT 3, WAIT 2, DEPTH 16).
module tb_dmem_banked_ctrl;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  sel;

   logic [2:0]  vld;
   logic [2:0]  rdy;
   logic [2:0]  rvld;
   logic [2:0]  rerr;
   logic [31:0] rdat [3];

   int n_checks;
   int n_fail;

   assign vld[0] = req_valid && (sel == 2'd0);
   assign vld[1] = req_valid && (sel == 2'd1);
   assign vld[2] = req_valid && (sel == 2'd2);

   dmem_banked_ctrl #(.DEPTH_WORDS(8192), .ADDR_W(32), .WAIT_CYCLES(3)) dut_w3 (
      .clock(clock), .reset(reset), .req_valid(vld[0]), .req_ready(rdy[0]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[0]),
      .resp_rdata(rdat[0]), .resp_err(rerr[0]));

   dmem_banked_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_CYCLES(2)) dut_w2 (
      .clock(clock), .reset(reset), .req_valid(vld[1]), .req_ready(rdy[1]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[1]),
      .resp_rdata(rdat[1]), .resp_err(rerr[1]));

   dmem_banked_ctrl #(.DEPTH_WORDS(16), .ADDR_W(32), .WAIT_CYCLES(0)) dut_d16 (
      .clock(clock), .reset(reset), .req_valid(vld[2]), .req_ready(rdy[2]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rvld[2]),
      .resp_rdata(rdat[2]), .resp_err(rerr[2]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One full transaction on instance s; lat is the response cycle after accept (-1 on timeout).
   task automatic do_req(input logic [1:0] s, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
      int n;
      sel = s; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd; req_valid = 1'b1;
      n = 0;
      while (!rdy[s] && n < 20) begin
         @(posedge clock); #1; n++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rvld[s] && lat < 40) begin
         @(posedge clock); #1; lat++;
      end
      rd = rdat[s];
      er = rerr[s];
      if (!rvld[s]) begin
         lat = -1;
         n_checks++; n_fail++;
         $display("FAIL req_timeout: no response from instance %0d for addr %h", s, a);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         n_checks += 4;
         if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 1", i, rdy[i]); end
         if (rvld[i] !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid[%0d]: got %b expected 0", i, rvld[i]); end
         if (rdat[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", i, rdat[i]); end
         if (rerr[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b expected 0", i, rerr[i]); end
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] rd; logic er; int lat; int seen;
      do_req(2'd0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, rd, er, lat);
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL w3_latency: got %0d expected 5", lat); end
      sel = 2'd0; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40;
      req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
      for (int n = 0; n < 20 && !rdy[0]; n++) begin @(posedge clock); #1; end
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL busy_ready: got %b expected 0", rdy[0]); end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL async_reset_ready: got %b expected 1", rdy[0]); end
      @(posedge clock); #1;
      reset = 1'b0;
      seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clock); #1;
         if (rvld[0]) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL discarded_resp: got %0d pulses expected 0", seen); end
      do_req(2'd0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h01020304) begin n_fail++; $display("FAIL discarded_store: got %h expected 01020304", rd); end
   endtask

   task automatic test_sized_rw();
      logic [31:0] rd; logic er; int lat;
      do_req(2'd0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, rd, er, lat);
      n_checks += 2;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", rd); end
      if (er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", er); end
      do_req(2'd0, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00000033) begin n_fail++; $display("FAIL lb_101: got %h expected 00000033", rd); end
      do_req(2'd0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00001122) begin n_fail++; $display("FAIL lhu_102: got %h expected 00001122", rd); end
      do_req(2'd0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080, rd, er, lat);
      do_req(2'd0, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_103: got %h expected FFFFFF80", rd); end
      do_req(2'd0, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_103: got %h expected 00000080", rd); end
      do_req(2'd0, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h80223344) begin n_fail++; $display("FAIL lw_100: got %h expected 80223344", rd); end
      do_req(2'd0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFF8022) begin n_fail++; $display("FAIL lh_102: got %h expected FFFF8022", rd); end
      do_req(2'd0, 1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFEF00D, rd, er, lat);
      do_req(2'd0, 1'b1, 2'b01, 1'b0, 32'h104, 32'h0000A5B6, rd, er, lat);
      do_req(2'd0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hCAFEA5B6) begin n_fail++; $display("FAIL sh_merge: got %h expected CAFEA5B6", rd); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; logic er; int lat;
      sel = 2'd1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h8; req_wdata = 32'h5555AAAA;
      for (int n = 0; n < 20 && !rdy[1]; n++) begin @(posedge clock); #1; end
      req_valid = 1'b1;
      n_checks++;
      if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_c0: got %b expected 1", rdy[1]); end
      for (int c = 1; c <= 6; c++) begin
         @(posedge clock); #1;
         n_checks += 2;
         if (rdy[1] !== (c == 5)) begin n_fail++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, rdy[1], (c == 5)); end
         if (rvld[1] !== (c == 4)) begin n_fail++; $display("FAIL b2b_resp_c%0d: got %b expected %b", c, rvld[1], (c == 4)); end
      end
      req_valid = 1'b0;
      do_req(2'd1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat);
      n_checks += 2;
      if (rd !== 32'h5555AAAA) begin n_fail++; $display("FAIL b2b_readback: got %h expected 5555AAAA", rd); end
      if (lat !== 4) begin n_fail++; $display("FAIL w2_latency: got %0d expected 4", lat); end
   endtask

   task automatic test_misalign();
      logic [31:0] rd; logic er; int lat;
      logic [31:0] exp_lw; logic exp_er; logic [31:0] exp_word; logic [31:0] exp_lh;
`ifdef DMEM_ALIGN_CHECK_EN
      exp_lw = 32'h0; exp_er = 1'b1; exp_word = 32'h80223344; exp_lh = 32'h0;
`else
      exp_lw = 32'h80223344; exp_er = 1'b0; exp_word = 32'h99887766; exp_lh = 32'h00007766;
`endif
      do_req(2'd0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, er, lat);
      n_checks += 2;
      if (rd !== exp_lw) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h expected %h", rd, exp_lw); end
      if (er !== exp_er) begin n_fail++; $display("FAIL lw_misalign_err: got %b expected %b", er, exp_er); end
      do_req(2'd0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h99887766, rd, er, lat);
      n_checks++;
      if (er !== exp_er) begin n_fail++; $display("FAIL sw_misalign_err: got %b expected %b", er, exp_er); end
      do_req(2'd0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== exp_word) begin n_fail++; $display("FAIL sw_misalign_word: got %h expected %h", rd, exp_word); end
      do_req(2'd0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, rd, er, lat);
      n_checks += 2;
      if (rd !== exp_lh) begin n_fail++; $display("FAIL lh_misalign_rdata: got %h expected %h", rd, exp_lh); end
      if (er !== exp_er) begin n_fail++; $display("FAIL lh_misalign_err: got %b expected %b", er, exp_er); end
      do_req(2'd0, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lat);
      n_checks += 2;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvd_load_rdata: got %h expected 0", rd); end
      if (er !== 1'b1) begin n_fail++; $display("FAIL rsvd_load_err: got %b expected 1", er); end
      do_req(2'd0, 1'b1, 2'b11, 1'b0, 32'h100, 32'hFFFFFFFF, rd, er, lat);
      n_checks++;
      if (er !== 1'b1) begin n_fail++; $display("FAIL rsvd_store_err: got %b expected 1", er); end
      do_req(2'd0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== exp_word) begin n_fail++; $display("FAIL rsvd_store_nowrite: got %h expected %h", rd, exp_word); end
   endtask

   task automatic test_alias();
      logic [31:0] rd; logic er; int lat;
      do_req(2'd2, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA1B2C3D4, rd, er, lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL w0_latency: got %0d expected 2", lat); end
      do_req(2'd2, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL alias_0: got %h expected A1B2C3D4", rd); end
      do_req(2'd2, 1'b0, 2'b10, 1'b0, 32'hFFFF0080, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL alias_high: got %h expected A1B2C3D4", rd); end
   endtask

   task automatic test_reset_in_resp();
      sel = 2'd2; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0; req_valid = 1'b1;
      for (int n = 0; n < 20 && !rdy[2]; n++) begin @(posedge clock); #1; end
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (rvld[2] !== 1'b1) begin n_fail++; $display("FAIL resp_before_reset: got %b expected 1", rvld[2]); end
      #2 reset = 1'b1;
      #1;
      n_checks += 2;
      if (rvld[2] !== 1'b0) begin n_fail++; $display("FAIL resp_cleared_by_reset: got %b expected 0", rvld[2]); end
      if (rdat[2] !== 32'h0) begin n_fail++; $display("FAIL rdata_cleared_by_reset: got %h expected 0", rdat[2]); end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; sel = 2'd0;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge clock); #1;
      test_reset_mid_busy();
      test_sized_rw();
      test_back_to_back();
      test_misalign();
      test_alias();
      test_reset_in_resp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_banked_ctrl.md
Name: dmem_banked_ctrl

Overview:
Parametrised data memory controller, the successor to the single-cycle data memory of the MIPS datapath. It provides sized load/store (byte, half, word) with sign or zero extension, little-endian byte lanes and a configurable wait-state count. A valid/ready request channel and a one-cycle response pulse let a multi-cycle or pipelined core stall on memory.

Parameters:
DEPTH_WORDS, 8192, number of 32-bit words in the array; power of two, at least 2.
ADDR_W, 32, width of the byte address input.
WAIT_CYCLES, 0, extra stall cycles inserted before each array access; 0 to 15.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  one-cycle response/acknowledge pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  request rejected; qualified by resp_valid.

Behaviour:
- Reset (async, active-high) values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, wait counter 0. Array contents are not reset.
- Word index = req_addr[2 +: log2(DEPTH_WORDS)]. Higher address bits are ignored, so addresses alias with wrap-around modulo DEPTH_WORDS*4.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid at a rising edge, latch all req_* fields, load the counter with WAIT_CYCLES, and go to BUSY.
- BUSY: req_ready=0. If the counter is nonzero, decrement it. If the counter is 0, perform the array access at that edge, register resp_rdata/resp_err, and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next edge returns to IDLE.
- Latency: resp_valid is high in cycle accept+WAIT_CYCLES+2. Sustained throughput is one request per WAIT_CYCLES+3 cycles.
- Store: only the addressed byte lanes are written. Byte lane = addr[1:0]; half occupies lanes addr[1]*2 and addr[1]*2+1; word writes all four lanes. Other bytes of the word are preserved.
- Load: select the lanes, then sign- or zero-extend per req_unsigned. Word ignores req_unsigned.
- Reserved size 11: resp_err=1, no write, resp_rdata=0.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0) is handled per the optional feature.
- Inputs are ignored while req_ready=0. Requester fields need not be held after acceptance.
- Reset asserted in BUSY discards the pending request; a store that has not yet committed never writes. Reset asserted in RESP clears resp_valid immediately.

Optional Feature:
Macro: DMEM_ALIGN_CHECK_EN.
- Defined: a misaligned half or word access completes with resp_err=1, resp_rdata=0 and no array write.
- Undefined: no alignment error. Half ignores addr[0]; word ignores addr[1:0]; the access proceeds aligned. The reserved-size error is still reported.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD;
  - FSM state enum;
  - width constant WORD_W=32;
  - function computing the 4-bit lane mask from size and addr[1:0].
- One combinational sub-module, dmem_lane_align: write-merge (old word, wdata, mask -> new word) and read-extract/extend (word, size, offset, unsigned -> rdata). It is shared with a future I-cache fill path.

Test Plan:
1. Reset mid-BUSY (WAIT_CYCLES=3) of store word 0xDEADBEEF to 0x40 -> no resp_valid; a later load word from 0x40 returns the prior contents.
2. Store word 0x11223344 to 0x100, then load byte at 0x101 signed -> 0x00000033. Load half at 0x102 unsigned -> 0x00001122.
3. Store byte 0x80 to 0x103, then load byte 0x103 signed -> 0xFFFFFF80, unsigned -> 0x00000080; word at 0x100 -> 0x80223344.
4. WAIT_CYCLES=2, request held at a constant, valid-high level -> accept at cycle 0, resp_valid only in cycle 4, req_ready low in cycles 1-4, next accept in cycle 5.
5. Load word from 0x102 -> with DMEM_ALIGN_CHECK_EN: resp_err=1, rdata 0. Without it: rdata equals word at 0x100. req_size=11 -> resp_err=1 in both builds.
6. DEPTH_WORDS=16: store word to 0x0000_0040 -> aliases index 0; load word from 0x0 returns the stored value.
